mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder for the Simptel-O9 multicycle core. It sits on the far side of the datapath's memory port: it accepts the `MemRead`/`MemWrite` strobes and the address selected by `IorD`, then holds the request for a fixed number of wait states. It returns read data and a one-cycle `ready` pulse. The control unit must stall its current state until `ready`.

## Interface
- `ADDR_W`, 8 — word-index width; memory depth is 2**ADDR_W words
- `DATA_W`, 32 — data word width
- `WAIT_CYCLES`, 1 — wait states between accept and completion; legal range 0..15

- `clk`  in  1  system clock; rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_read`  in  1  read request; held by requester until `ready`
- `mem_write`  in  1  write request; held by requester until `ready`
- `addr`  in  32  byte address; word index = `addr[ADDR_W+1:2]`
- `wdata`  in  DATA_W  write data; held with `mem_write`
- `rdata`  out  DATA_W  read data; valid with `ready`, held until the next read completes
- `ready`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse, coincident with `ready`, flagging a rejected request

## Operation
- FSM states:
  - IDLE: no request in progress.
  - WAIT: counts down the wait states.
  - DONE: completes the request.
- Reset state: IDLE, `ready`=0, `err`=0, `rdata`=0, wait counter=0. Array contents are not reset.
- IDLE -> WAIT when exactly one of `mem_read`/`mem_write` is 1. Latch `addr`, `wdata` and the request type. Load the counter with WAIT_CYCLES.
- WAIT:
  - If the counter is 0, go to DONE.
  - Otherwise decrement the counter and stay in WAIT.
- WAIT -> DONE: on this edge, a write commits to the array and a read loads `rdata`. `ready` is 1 for the DONE cycle.
- DONE -> IDLE unconditionally. A request still asserted in IDLE is treated as new. The requester must drop its strobe in the cycle it sees `ready`.
- `mem_read` and `mem_write` both 1 in IDLE is a protocol error:
  - go directly to DONE with `ready`=1 and `err`=1;
  - no array access occurs and `rdata` is unchanged.
- Request inputs are ignored outside IDLE. Latched values are used, so input changes mid-request have no effect.
- Reset mid-request returns to IDLE immediately. A write that has not reached the WAIT->DONE edge is never committed.

## Timing
- Accept edge to `ready` high: WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, `ready` rises 2 edges after the request is first sampled in IDLE (IDLE->WAIT->DONE).
- Back-to-back requests: the minimum period is WAIT_CYCLES+3 cycles.
- The array read is synchronous. `rdata` is registered and has no combinational path from `addr`.

## Configuration
- `MEM_RESP_CHECK_EN` defined:
  - A request with `addr[1:0]`≠0 is rejected.
  - A request with any bit of `addr[31:ADDR_W+2]` set is also rejected.
  - A rejected request takes the normal wait-state path but performs no array access. It ends with `ready`=1 and `err`=1, and `rdata` is unchanged.
- Undefined:
  - The low two bits and the high bits of `addr` are ignored, so out-of-range addresses alias.
  - `err` asserts only for simultaneous read and write.

## Structure
- Shared package `simptel_pkg`:
  - word typedef `word_t` (32 bits);
  - FSM state enum `mem_state_t`;
  - default `ADDR_W`/`WAIT_CYCLES` constants, shared with the datapath.
- One sub-module, `mem_array`: a single-port synchronous RAM with write enable, parameterised by ADDR_W/DATA_W. The FSM, counter and check logic stay in `mem_responder`.

## Test plan
- Reset: assert `reset` mid-WAIT of a write to 0x10 with `wdata`=0xDEADBEEF. The FSM returns to IDLE and `ready`/`err`/`rdata`=0. A later read of 0x10 does not return 0xDEADBEEF.
- WAIT_CYCLES=1: write 0x12345678 to 0x20, then read 0x20. `ready` rises exactly 2 cycles after each accept edge and `rdata`=0x12345678 with `ready`.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4, with strobes dropped on `ready`. The period is 3 cycles and `rdata` tracks each word.
- `mem_read`=`mem_write`=1 at 0x8: `ready`=`err`=1 one cycle later. The array word is unchanged and `rdata` is unchanged.
- `MEM_RESP_CHECK_EN` on: a read of 0x6 and a write to 0x400 (ADDR_W=8) both give `err`=1 with `ready`. The array and `rdata` are unchanged.
- `MEM_RESP_CHECK_EN` off: a write to 0x400 with ADDR_W=8 lands at word 0, and a read of 0x0 returns it with `err`=0.

Source files
------------

// File: rtl/simptel_pkg.sv
// Shared Simptel-O9 types and defaults: word type, memory responder FSM states,
// and the address validity helper used when MEM_RESP_CHECK_EN is defined.
package simptel_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_WAIT_CYCLES = 1;

  // True when a byte address is misaligned or lies beyond a 2**aw word array.
  function automatic logic addr_bad(input word_t a, input int aw);
    word_t hi_mask;
    hi_mask = ~((word_t'(1) << (aw + 2)) - word_t'(1));
    return (a[1:0] != 2'b00) || ((a & hi_mask) != '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and registered (read-first) output.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder with fixed wait states and a one-cycle ready pulse.
// Define MEM_RESP_CHECK_EN to reject misaligned or out-of-range addresses with err.
module mem_responder
  import simptel_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  mem_state_t        state_reg;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              is_write_reg;
  logic              reject_reg;

  logic [ADDR_W-1:0] addr_word;
  logic              req_reject;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  assign addr_word = addr[ADDR_W+1:2];

`ifdef MEM_RESP_CHECK_EN
  assign req_reject = addr_bad(addr, ADDR_W);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[1:0], addr[31:ADDR_W+2]};
  assign req_reject       = 1'b0;
`endif

  // The RAM is addressed from the live bus while idle so its registered output
  // already holds the requested word by the first WAIT cycle, even with zero waits.
  always_comb begin
    ram_addr = addr_reg;
    ram_we   = 1'b0;
    if (state_reg == ST_IDLE) begin
      ram_addr = addr_word;
    end
    if (state_reg == ST_WAIT && cnt_reg == 4'd0 && is_write_reg && !reject_reg) begin
      ram_we = 1'b1;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_reg),
    .q    (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      reject_reg   <= 1'b0;
      rdata        <= '0;
      ready        <= 1'b0;
      err          <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_read && mem_write) begin
            state_reg <= ST_DONE;
            ready     <= 1'b1;
            err       <= 1'b1;
          end else if (mem_read || mem_write) begin
            state_reg    <= ST_WAIT;
            cnt_reg      <= WAIT_LOAD;
            addr_reg     <= addr_word;
            wdata_reg    <= wdata;
            is_write_reg <= mem_write;
            reject_reg   <= req_reject;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ST_DONE;
            ready     <= 1'b1;
            err       <= reject_reg;
            if (!is_write_reg && !reject_reg) begin
              rdata <= ram_q;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver pushes expected responses from a
// word-array model, a negedge monitor pops and compares on every ready pulse.
module tb_mem_responder;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int WAIT_CYCLES = 1;
  localparam int DEPTH       = 2**ADDR_W;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        mem_read  = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr      = '0;
  logic [31:0] wdata     = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  mem_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      ready_cyc;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  int          req_id = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match exactly one outstanding request.
  always @(negedge clk) begin
    if (!reset && ready === 1'b1) begin
      exp_t e;
      check("pending_on_ready", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.ready_cyc));
        check("err", 64'(err), 64'(e.err));
        check("rdata", 64'(rdata), 64'(e.rdata));
        $display("req %0d: cyc=%0d err=%0b rdata=%08h", e.id, cyc, err, rdata);
      end
    end
  end

  // Reference: a request is rejected for both strobes, or (with checking) for an
  // unaligned or out-of-range byte address; otherwise word index = (addr/4) mod depth.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   bad;
    int   idx;
    int   n;
    bad = rd && wr;
`ifdef MEM_RESP_CHECK_EN
    if ((a % 4) != 0 || a >= 32'(4 * DEPTH)) bad = 1'b1;
`endif
    idx = int'((a / 4) % DEPTH);
    e.id        = req_id++;
    e.ready_cyc = (rd && wr) ? cyc + 1 : cyc + WAIT_CYCLES + 2;
    e.err       = bad;
    if (!bad && wr) begin
      model_mem[idx] = d;
    end else if (!bad && rd) begin
      model_rdata = model_mem[idx];
    end
    e.rdata = model_rdata;
    sb.push_back(e);

    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (ready === 1'b1 || n >= 40) break;
      // Bus noise while the request is in flight must not matter.
      addr  = $urandom;
      wdata = $urandom;
    end
    if (ready !== 1'b1) check("ready_timeout", 64'(ready), 64'd1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill every word so all later reads have known contents.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i == 4) v = 32'hA5A5_0010;
      if (i == 5) v = 32'h1234_ABCD;
      do_req(1'b0, 1'b1, 32'(i * 4), v);
    end
    do_req(1'b1, 1'b0, 32'h14, 32'h0);

    // Reset in the middle of a write's wait states.
    mem_write = 1'b1;
    addr      = 32'h10;
    wdata     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_err", 64'(err), 64'd0);
    check("midreset_rdata", 64'(rdata), 64'd0);
    mem_write   = 1'b0;
    model_rdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    check("aborted_write_absent", 64'(rdata == 32'hDEAD_BEEF), 64'd0);

    do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 1'b1, 32'h8, 32'h5555_5555);
    do_req(1'b1, 1'b0, 32'h8, 32'h0);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    do_req(1'b1, 1'b0, 32'h4, 32'h0);
`ifdef MEM_RESP_CHECK_EN
    do_req(1'b1, 1'b0, 32'h6, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
`else
    do_req(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
`endif

    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH - 1) * 4);
      if (kind == 0) do_req(1'b1, 1'b1, a, $urandom);
      else if (kind <= 4) do_req(1'b0, 1'b1, a, $urandom);
      else do_req(1'b1, 1'b0, a, $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
